// File: rtl/riscv_retire_checker_if.sv
// Core-side bus of the retire checker.
// Table load port plus the retire stream sampled from the core.
interface riscv_retire_checker_if #(
  parameter int IWIDTH = 5
);
  logic              LOAD_EN;
  logic [IWIDTH-1:0] LOAD_IDX;
  logic [31:0]       LOAD_NUM_INST;
  logic [31:0]       LOAD_ANS;
  logic [31:0]       NUM_INST;
  logic [31:0]       OUTPUT_PORT;
  logic              HALT;

  modport master (
    output LOAD_EN,
    output LOAD_IDX,
    output LOAD_NUM_INST,
    output LOAD_ANS,
    output NUM_INST,
    output OUTPUT_PORT,
    output HALT
  );

  modport slave (
    input LOAD_EN,
    input LOAD_IDX,
    input LOAD_NUM_INST,
    input LOAD_ANS,
    input NUM_INST,
    input OUTPUT_PORT,
    input HALT
  );
endinterface

// File: rtl/riscv_retire_checker.sv
// Retire checker: walks a (retire count, answer) table as the core
// retires and reports pass/fail, first failure and cycle count.
module riscv_retire_checker #(
  parameter int NUM_TEST       = 22,
  parameter int IWIDTH         = 5,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  CLK,
  input  logic                  RST,
  riscv_retire_checker_if.slave bus,
  input  logic [IWIDTH:0]       TEST_COUNT,
  input  logic                  START,
  input  logic                  CLEAR,
  output logic                  DONE,
  output logic                  PASS,
  output logic [1:0]            FAIL_CODE,
  output logic [IWIDTH-1:0]     FAIL_IDX,
  output logic [31:0]           FAIL_VAL,
  output logic [IWIDTH:0]       PASS_CNT,
  output logic [31:0]           CYCLE_CNT
);

  typedef logic [IWIDTH:0]   cnt_t;
  typedef logic [IWIDTH-1:0] idx_t;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_PASSED = 2'd2;
  localparam logic [1:0] S_FAILED = 2'd3;

  localparam logic [1:0] FC_NONE = 2'd0;
  localparam logic [1:0] FC_MISS = 2'd1;
  localparam logic [1:0] FC_SKIP = 2'd2;
  localparam logic [1:0] FC_TOUT = 2'd3;

  localparam cnt_t        NT = cnt_t'(NUM_TEST);
  localparam logic [31:0] TO = 32'(TIMEOUT_CYCLES);

  logic [31:0] num_tab [NUM_TEST];
  logic [31:0] ans_tab [NUM_TEST];

  logic [1:0]  state_q;
  logic [1:0]  state_d;
  cnt_t        ptr_q;
  cnt_t        ptr_d;
  cnt_t        cnt_q;
  cnt_t        cnt_d;
  logic [1:0]  fc_q;
  logic [1:0]  fc_d;
  idx_t        fidx_q;
  idx_t        fidx_d;
  logic [31:0] fval_q;
  logic [31:0] fval_d;
  logic [31:0] cyc_q;
  logic [31:0] cyc_d;

  logic        in_idle;
  logic        in_run;
  logic        in_done;
  logic        tab_we;
  idx_t        rd_idx;
  logic        live;
  logic [31:0] cur_num;
  logic [31:0] cur_ans;
  logic        hit;
  logic        good;
  logic        miss;
  logic        skip;
  logic        tout;
  cnt_t        ptr_adv;
  cnt_t        cnt_lim;
  logic [31:0] cyc_inc;

  // one-hot view of the current state
  always_comb begin
    in_idle = 1'b0;
    in_run  = 1'b0;
    in_done = 1'b0;
    unique case (state_q)
      S_IDLE:  in_idle = 1'b1;
      S_RUN:   in_run  = 1'b1;
      default: in_done = 1'b1;
    endcase
  end

  // out-of-range indices are dropped so the table never aliases
  assign tab_we = in_idle & bus.LOAD_EN
                & ({1'b0, bus.LOAD_IDX} < NT);

  // table write port; contents survive reset and CLEAR
  always_ff @(posedge CLK) begin
    if (tab_we) begin
      num_tab[bus.LOAD_IDX] <= bus.LOAD_NUM_INST;
      ans_tab[bus.LOAD_IDX] <= bus.LOAD_ANS;
    end
  end

  // live implies ptr < count <= NUM_TEST, so rd_idx is in range
  assign rd_idx  = ptr_q[IWIDTH-1:0];
  assign live    = in_run & (ptr_q < cnt_q);
  assign cur_num = live ? num_tab[rd_idx] : '0;
  assign cur_ans = live ? ans_tab[rd_idx] : '0;

  assign hit  = live & (bus.NUM_INST == cur_num);
  assign good = hit & (bus.OUTPUT_PORT == cur_ans);
  assign miss = hit & ~good;
  assign skip = live & ~hit & (bus.NUM_INST > cur_num);

  assign ptr_adv = ptr_q + cnt_t'(good);
  assign cnt_lim = (TEST_COUNT > NT) ? NT : TEST_COUNT;
  assign cyc_inc = (cyc_q == TO) ? cyc_q : cyc_q + 32'd1;
  assign tout    = (cyc_q + 32'd1) == TO;

  // next-state and result selection
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    fc_d    = fc_q;
    fidx_d  = fidx_q;
    fval_d  = fval_q;
    cyc_d   = cyc_q;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_RUN;
          cnt_d   = cnt_lim;
          ptr_d   = '0;
          cyc_d   = '0;
          fc_d    = FC_NONE;
          fidx_d  = '0;
          fval_d  = '0;
        end
      end
      S_RUN: begin
        cyc_d = cyc_inc;
        ptr_d = ptr_adv;
        if (miss) begin
          state_d = S_FAILED;
          fc_d    = FC_MISS;
          fidx_d  = ptr_q[IWIDTH-1:0];
          fval_d  = bus.OUTPUT_PORT;
        end else if (skip) begin
          state_d = S_FAILED;
          fc_d    = FC_SKIP;
          fidx_d  = ptr_q[IWIDTH-1:0];
        end else if (bus.HALT) begin
          if (ptr_adv == cnt_q) begin
            state_d = S_PASSED;
          end else begin
            state_d = S_FAILED;
            fc_d    = FC_SKIP;
            fidx_d  = ptr_adv[IWIDTH-1:0];
          end
        end else if (tout) begin
          state_d = S_FAILED;
          fc_d    = FC_TOUT;
          fidx_d  = ptr_adv[IWIDTH-1:0];
        end
      end
      default: begin
        if (CLEAR) begin
          state_d = S_IDLE;
          fc_d    = FC_NONE;
          fidx_d  = '0;
          fval_d  = '0;
        end
      end
    endcase
  end

  // state and result registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      fc_q    <= FC_NONE;
      fidx_q  <= '0;
      fval_q  <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      fc_q    <= fc_d;
      fidx_q  <= fidx_d;
      fval_q  <= fval_d;
      cyc_q   <= cyc_d;
    end
  end

  assign DONE      = in_done;
  assign PASS      = (state_q == S_PASSED);
  assign FAIL_CODE = fc_q;
  assign FAIL_IDX  = fidx_q;
  assign FAIL_VAL  = fval_q;
  assign PASS_CNT  = ptr_q;
  assign CYCLE_CNT = cyc_q;

endmodule

// File: doc/riscv_retire_checker.md
Name: riscv_retire_checker

Overview:
- Synthesizable self-check block that sits directly downstream of RISCV_TOP; consumes its NUM_INST, OUTPUT_PORT and HALT outputs.
- Holds a loadable table of (instruction-count, expected-answer) pairs and walks it in order as instructions retire.
- Reports pass/fail, first-failure index and value, and a cycle count. Lets FPGA and gate-level runs self-check without behavioural $display logic.

Parameters:
- NUM_TEST, 22, table depth (entries).
- IWIDTH, 5, index width; 2**IWIDTH >= NUM_TEST.
- TIMEOUT_CYCLES, 1000000, maximum RUN cycles before a timeout fail.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous active-high reset.
- LOAD_EN  in  1  write one table entry this cycle; honoured only in IDLE.
- LOAD_IDX  in  IWIDTH  entry index; indices >= NUM_TEST are ignored.
- LOAD_NUM_INST  in  32  retire count at which to check this entry.
- LOAD_ANS  in  32  expected OUTPUT_PORT value.
- TEST_COUNT  in  IWIDTH+1  number of valid entries; latched on START.
- START  in  1  IDLE->RUN pulse.
- CLEAR  in  1  terminal state -> IDLE; the table is kept.
- NUM_INST  in  32  core retired-instruction count.
- OUTPUT_PORT  in  32  core output value.
- HALT  in  1  core halt.
- DONE  out  1  a terminal state has been reached.
- PASS  out  1  valid with DONE.
- FAIL_CODE  out  2  0 none, 1 mismatch, 2 skipped/incomplete, 3 timeout.
- FAIL_IDX  out  IWIDTH  entry index at failure.
- FAIL_VAL  out  32  OUTPUT_PORT sampled at a mismatch; otherwise 0.
- PASS_CNT  out  IWIDTH+1  entries passed so far.
- CYCLE_CNT  out  32  cycles spent in RUN.

Behaviour:
- Reset: RST=1 at an edge takes effect at that edge.
  - State -> IDLE.
  - All outputs, ptr and latched count -> 0.
  - Table contents need not reset.
  - Reset mid-RUN aborts with no DONE pulse.
- States and transitions:
  - IDLE: LOAD_EN writes the entry. START latches TEST_COUNT, clears ptr/PASS_CNT/CYCLE_CNT, -> RUN.
  - RUN: CYCLE_CNT increments every cycle in RUN. Evaluation per edge, in priority order:
    - a) If ptr<count and NUM_INST==num[ptr]:
      - OUTPUT_PORT==ans[ptr]: ptr++, PASS_CNT++.
      - Otherwise: FAIL_CODE=1, FAIL_IDX=ptr, FAIL_VAL=OUTPUT_PORT, -> FAILED.
    - b) Else if ptr<count and NUM_INST>num[ptr] (unsigned): FAIL_CODE=2, FAIL_IDX=ptr, -> FAILED.
    - c) If HALT and no fail this edge: use ptr after step a).
      - ptr==count: -> PASSED.
      - Otherwise: FAIL_CODE=2, FAIL_IDX=ptr, -> FAILED.
    - d) Else if CYCLE_CNT+1==TIMEOUT_CYCLES: FAIL_CODE=3, FAIL_IDX=ptr, -> FAILED.
  - PASSED / FAILED: DONE=1; PASS=1 only in PASSED. All results and counters are frozen. CLEAR -> IDLE with DONE/PASS/FAIL_* cleared.
- Latency and ordering:
  - Outputs are registered. An event sampled at edge k is visible after edge k; there is no combinational path from inputs to outputs.
  - At most one entry is checked per cycle.
  - Entries must be strictly ascending in num. Equal consecutive entries are checked on consecutive cycles against whatever OUTPUT_PORT holds then.
  - A NUM_INST held over several cycles (multicycle core) is checked once per entry.
- Boundaries:
  - count=0: HALT -> PASSED immediately.
  - count>NUM_TEST is clamped to NUM_TEST.
  - LOAD_EN / START outside IDLE are ignored.
  - CLEAR in IDLE or RUN is ignored.
  - START and LOAD_EN in the same IDLE cycle: the load is written, then RUN begins; the new entry is visible from the first RUN cycle.
  - HALT on the same edge as the final matching check -> PASSED.
  - CYCLE_CNT saturates at TIMEOUT_CYCLES.

Test Plan:
- Load {1:0x5, 2:0x0, 3:0x1}, TEST_COUNT=3, START; drive NUM_INST 0..3 with matching OUTPUT_PORT, HALT with NUM_INST=3 -> DONE=1, PASS=1, PASS_CNT=3, FAIL_CODE=0.
- Same table, OUTPUT_PORT=0x6 at NUM_INST=1 -> next edge DONE=1, PASS=0, FAIL_CODE=1, FAIL_IDX=0, FAIL_VAL=0x6, PASS_CNT=0.
- Same table, NUM_INST steps 1 -> 3 (skipping 2), port correct at 1 -> FAIL_CODE=2, FAIL_IDX=1, PASS_CNT=1.
- TIMEOUT_CYCLES=16, one entry never reached, no HALT -> DONE after 16 RUN cycles, CYCLE_CNT=16, FAIL_CODE=3, FAIL_IDX=0.
- HALT after 2 of 3 entries pass -> FAIL_CODE=2, FAIL_IDX=2. HALT together with the 3rd match -> PASS=1.
- RST high mid-RUN (PASS_CNT=2) -> next edge all outputs 0, state IDLE. LOAD_EN during RUN leaves the table unchanged (re-run passes with original answers). CLEAR from FAILED -> DONE=0, and a new START works.
